// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter giving two requesters access to one single-port synchronous memory.
// Partial writes run a read-modify-write; one transaction in flight, registered outputs.
module rom_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m0_ready,
  output logic              m1_ready,
  output logic [31:0]       rsp_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
  state_t state;
  logic last_grant, gnt, pick;
  logic [ADDR_W-1:0] pick_addr;
  logic [31:0] pick_wdata, wdata_q, merged;
  logic [3:0] pick_wstrb, wstrb_q;
  // last_grant names the requester served last; on a tie the other one wins
  always_comb begin
    pick = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
    pick_addr = pick ? m1_addr : m0_addr;
    pick_wdata = pick ? m1_wdata : m0_wdata;
    pick_wstrb = pick ? m1_wstrb : m0_wstrb;
  end
  for (genvar b = 0; b < 4; b++) begin : g_merge
    assign merged[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : mem_rdata[8*b +: 8];
  end
  // mem_addr doubles as the latched request address for the whole transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last_grant <= 1'b1;
      gnt <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      rsp_rdata <= '0;
      mem_wen <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: if (m0_valid || m1_valid) begin
          gnt <= pick;
          last_grant <= pick;
          mem_addr <= pick_addr;
          wdata_q <= pick_wdata;
          wstrb_q <= pick_wstrb;
          if (pick_wstrb == 4'hF) begin
            mem_wen <= 1'b1;
            mem_wdata <= pick_wdata;
            state <= WR;
          end else state <= RD;
        end
        RD: state <= CAP;
        CAP: if (wstrb_q == 4'h0) begin
          rsp_rdata <= mem_rdata;
          m0_ready <= ~gnt;
          m1_ready <= gnt;
          state <= RESP;
        end else begin
          mem_wen <= 1'b1;
          mem_wdata <= merged;
          state <= WR;
        end
        WR: begin
          m0_ready <= ~gnt;
          m1_ready <= gnt;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench with a transaction-level latency/memory model checked every cycle.
module tb_rom_arbiter;
  logic clk, resetn;
  logic m0_valid, m1_valid, m0_ready, m1_ready, mem_wen;
  logic [7:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wdata, m1_wdata, rsp_rdata, mem_wdata, mem_rdata;
  logic [3:0] m0_wstrb, m1_wstrb;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic bd_en;
  logic [7:0] bd_a;
  logic [31:0] bd_d;
  int errors = 0, checks = 0, wen_cnt = 0;
  bit run = 0;

  rom_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m0_ready(m0_ready), .m1_ready(m1_ready), .rsp_rdata(rsp_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // bench-owned synchronous memory with a backdoor load port
  always @(posedge clk) begin
    if (bd_en) mem[bd_a] <= bd_d;
    else if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // model: each accepted request has a fixed latency (read 3, full write 2, partial 4 edges,
  // acceptance edge counted as 1); the write lands on the ready edge, the edge after is dead
  bit busy = 0;
  int k = 0, lat = 0;
  logic who = 0, last = 1;
  logic [7:0] t_addr;
  logic [31:0] t_wd;
  logic [3:0] t_st;
  logic e_r0 = 0, e_r1 = 0, e_wen = 0;
  logic [31:0] e_rd = 0;
  always @(posedge clk or negedge resetn) begin
    if (bd_en) ref_mem[bd_a] = bd_d;
    if (!resetn) begin
      busy = 0; k = 0; last = 1;
      e_r0 = 0; e_r1 = 0; e_wen = 0; e_rd = 0;
    end else begin
      e_r0 = 0; e_r1 = 0; e_wen = 0;
      if (busy) begin
        k++;
        if (k == lat) begin
          if (who) e_r1 = 1; else e_r0 = 1;
          if (t_st == 4'h0) e_rd = ref_mem[t_addr];
          else for (int b = 0; b < 4; b++) if (t_st[b]) ref_mem[t_addr][8*b +: 8] = t_wd[8*b +: 8];
        end else if (k == lat + 1) busy = 0;
        if (k == lat - 1 && t_st != 4'h0) e_wen = 1;
      end else if (m0_valid || m1_valid) begin
        who = (m0_valid && m1_valid) ? !last : m1_valid;
        last = who;
        busy = 1;
        k = 1;
        t_addr = who ? m1_addr : m0_addr;
        t_wd = who ? m1_wdata : m0_wdata;
        t_st = who ? m1_wstrb : m0_wstrb;
        lat = (t_st == 4'h0) ? 3 : (t_st == 4'hF) ? 2 : 4;
        if (lat == 2) e_wen = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_wen) wen_cnt++;
    if (run) begin
      chk("cyc_m0_ready", 32'(m0_ready), 32'(e_r0));
      chk("cyc_m1_ready", 32'(m1_ready), 32'(e_r1));
      chk("cyc_mem_wen", 32'(mem_wen), 32'(e_wen));
      chk("cyc_rsp_rdata", rsp_rdata, e_rd);
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #2 bd_en = 1; bd_a = a; bd_d = d;
    @(posedge clk); #2 bd_en = 0;
  endtask

  // issue one request, scramble the inputs after acceptance, count edges up to ready
  task automatic txn(input bit m, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output int n, output logic [31:0] rd);
    repeat (2) @(posedge clk);
    #2;
    if (m) begin m1_valid = 1; m1_addr = a; m1_wdata = wd; m1_wstrb = st; end
    else begin m0_valid = 1; m0_addr = a; m0_wdata = wd; m0_wstrb = st; end
    n = 0;
    rd = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        m0_valid = 0; m1_valid = 0;
        m0_addr = ~a; m1_addr = ~a; m0_wdata = ~wd; m1_wdata = ~wd;
      end
      if (m ? m1_ready : m0_ready) begin
        rd = rsp_rdata;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n, w0, cnt;
    int order [4];
    logic [31:0] rd;
    resetn = 0; bd_en = 0; bd_a = 0; bd_d = 0;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    preload(8'h10, 32'hAABBCCDD);
    preload(8'h20, 32'h11223344);
    preload(8'h05, 32'h55667788);
    run = 1;
    @(posedge clk); #2;
    chk("rst_m0_ready", 32'(m0_ready), 0);
    chk("rst_m1_ready", 32'(m1_ready), 0);
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    resetn = 1;
    // read
    w0 = wen_cnt;
    txn(0, 8'h10, 32'h0, 4'h0, n, rd);
    chk("read_latency", n, 3);
    chk("read_data", rd, 32'hAABBCCDD);
    chk("read_no_write", wen_cnt - w0, 0);
    // partial write
    w0 = wen_cnt;
    txn(1, 8'h20, 32'hAABBCCDD, 4'b0101, n, rd);
    chk("pwr_latency", n, 4);
    chk("pwr_wen_cycles", wen_cnt - w0, 1);
    chk("pwr_mem", mem[8'h20], 32'h11BB33DD);
    // full write then read back
    w0 = wen_cnt;
    txn(0, 8'hFF, 32'hDEADBEEF, 4'hF, n, rd);
    chk("fwr_latency", n, 2);
    chk("fwr_wen_cycles", wen_cnt - w0, 1);
    chk("fwr_mem", mem[8'hFF], 32'hDEADBEEF);
    txn(0, 8'hFF, 32'h0, 4'h0, n, rd);
    chk("fwr_readback", rd, 32'hDEADBEEF);
    chk("fwr_read_latency", n, 3);
    // contention straight after reset, both held
    @(posedge clk); #2 resetn = 0;
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    @(posedge clk); #2;
    m0_valid = 1; m0_addr = 8'h10; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 8'h20; m1_wstrb = 0;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(posedge clk); #1;
      if (m0_ready) begin order[cnt] = 0; cnt++; end
      else if (m1_ready) begin order[cnt] = 1; cnt++; end
    end
    m0_valid = 0; m1_valid = 0;
    chk("arb_grants", cnt, 4);
    for (int i = 0; i < cnt; i++) chk("arb_order", order[i], i % 2);
    // reset while a partial write sits in CAP
    repeat (2) @(posedge clk);
    #2;
    m0_valid = 1; m0_addr = 8'h05; m0_wdata = 32'hCAFEF00D; m0_wstrb = 4'b0011;
    @(posedge clk); #2 m0_valid = 0;
    @(posedge clk); #2 resetn = 0;
    w0 = wen_cnt;
    #1 chk("abort_mem_addr", 32'(mem_addr), 0);
    repeat (3) @(posedge clk);
    #2 resetn = 1;
    chk("abort_no_write", wen_cnt - w0, 0);
    chk("abort_mem", mem[8'h05], 32'h55667788);
    txn(1, 8'h05, 32'h0, 4'h0, n, rd);
    chk("after_abort_latency", n, 3);
    chk("after_abort_data", rd, 32'h55667788);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
